// File: rtl/alu_sequencer.sv
// alu_sequencer: command front-end for the 8-bit six-control-bit ALU.
//
// Accepts opcode/operand requests over a valid/ready handshake, encodes each
// opcode into the ALU control word (zx nx zy ny f no) and returns the result
// plus zr/ng flags over a second valid/ready handshake. Single-cycle opcodes
// spend one cycle in EXEC; MUL runs a fixed-length shift-add loop through the
// same external ALU.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_op/req_x/req_y payload
//   rsp_valid/rsp_ready      response handshake; rsp_o/rsp_zr/rsp_ng payload
//   alu_x, alu_y, alu_zx..no operands and control word driven to the ALU
//   alu_o, alu_zr, alu_ng    combinational ALU result and flags

module alu_sequencer #(
    parameter int unsigned W         = 8,
    // Must equal W: each step consumes one multiplier bit.
    parameter int unsigned MUL_STEPS = 8
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_x,
    input  logic [W-1:0] req_y,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_o,
    output logic         rsp_zr,
    output logic         rsp_ng,

    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic         alu_zx,
    output logic         alu_nx,
    output logic         alu_zy,
    output logic         alu_ny,
    output logic         alu_f,
    output logic         alu_no,
    input  logic [W-1:0] alu_o,
    input  logic         alu_zr,
    input  logic         alu_ng
);

    localparam int unsigned CntW = $clog2(MUL_STEPS + 1);

    localparam logic [3:0] OpMul = 4'd15;

    // Control words, bit order {zx, nx, zy, ny, f, no}.
    localparam logic [5:0] CtrlZero    = 6'b101010;
    localparam logic [5:0] CtrlOne     = 6'b111111;
    localparam logic [5:0] CtrlNeg1    = 6'b111010;
    localparam logic [5:0] CtrlX       = 6'b001100;
    localparam logic [5:0] CtrlY       = 6'b110000;
    localparam logic [5:0] CtrlNotX    = 6'b001101;
    localparam logic [5:0] CtrlNotY    = 6'b110001;
    localparam logic [5:0] CtrlNegX    = 6'b001111;
    localparam logic [5:0] CtrlXorY    = 6'b010101;
    localparam logic [5:0] CtrlXPlus1  = 6'b011111;
    localparam logic [5:0] CtrlYPlus1  = 6'b110111;
    localparam logic [5:0] CtrlXMinus1 = 6'b001110;
    localparam logic [5:0] CtrlXPlusY  = 6'b000010;
    localparam logic [5:0] CtrlXMinusY = 6'b010011;
    localparam logic [5:0] CtrlXAndY   = 6'b000000;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMult,
        StResp
    } state_e;

    function automatic logic [5:0] decode_op(input logic [3:0] op);
        logic [5:0] ctrl;
        case (op)
            4'd0:    ctrl = CtrlZero;
            4'd1:    ctrl = CtrlOne;
            4'd2:    ctrl = CtrlNeg1;
            4'd3:    ctrl = CtrlX;
            4'd4:    ctrl = CtrlY;
            4'd5:    ctrl = CtrlNotX;
            4'd6:    ctrl = CtrlNotY;
            4'd7:    ctrl = CtrlNegX;
            4'd8:    ctrl = CtrlXorY;
            4'd9:    ctrl = CtrlXPlus1;
            4'd10:   ctrl = CtrlYPlus1;
            4'd11:   ctrl = CtrlXMinus1;
            4'd12:   ctrl = CtrlXPlusY;
            4'd13:   ctrl = CtrlXMinusY;
            4'd14:   ctrl = CtrlXAndY;
            default: ctrl = CtrlXPlusY;  // MUL steps are additions
        endcase
        return ctrl;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_o_q, rsp_o_d;
    logic            rsp_zr_q, rsp_zr_d;
    logic            rsp_ng_q, rsp_ng_d;

    logic [5:0]      alu_ctrl;
    logic [W-1:0]    acc_next;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_o_d     = rsp_o_q;
        rsp_zr_d    = rsp_zr_q;
        rsp_ng_d    = rsp_ng_q;

        alu_x       = '0;
        alu_y       = '0;
        alu_ctrl    = CtrlZero;
        acc_next    = acc_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d     = req_op;
                    x_d      = req_x;
                    y_d      = req_y;
                    acc_d    = '0;
                    mcand_d  = req_x;
                    mplier_d = req_y;
                    cnt_d    = '0;
                    state_d  = (req_op == OpMul) ? StMult : StExec;
                end
            end

            StExec: begin
                alu_x       = x_q;
                alu_y       = y_q;
                alu_ctrl    = decode_op(op_q);
                rsp_o_d     = alu_o;
                rsp_zr_d    = alu_zr;
                rsp_ng_d    = alu_ng;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end

            StMult: begin
                // acc + (mcand << step) whenever the current multiplier bit is set.
                alu_x    = acc_q;
                alu_y    = mcand_q;
                alu_ctrl = CtrlXPlusY;
                acc_next = mplier_q[0] ? alu_o : acc_q;
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(MUL_STEPS - 1)) begin
                    rsp_o_d     = acc_next;
                    rsp_zr_d    = (acc_next == '0);
                    rsp_ng_d    = acc_next[W-1];
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_o_q     <= '0;
            rsp_zr_q    <= 1'b0;
            rsp_ng_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_o_q     <= rsp_o_d;
            rsp_zr_q    <= rsp_zr_d;
            rsp_ng_q    <= rsp_ng_d;
        end
    end

    // Gated by rst so the block never advertises readiness while held in reset.
    assign req_ready = (state_q == StIdle) && !rst;

    assign rsp_valid = rsp_valid_q;
    assign rsp_o     = rsp_o_q;
    assign rsp_zr    = rsp_zr_q;
    assign rsp_ng    = rsp_ng_q;

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctrl;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: models the external ALU, issues directed
// requests, and checks responses through a scoreboard queue drained by an
// independent monitor that also drives rsp_ready (with optional backpressure).

module tb_alu_sequencer;

    localparam int W = 8;

    localparam logic [5:0] CtrlZero   = 6'b101010;
    localparam logic [5:0] CtrlOne    = 6'b111111;
    localparam logic [5:0] CtrlXPlusY = 6'b000010;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = '0;
    logic [W-1:0] req_x = '0;
    logic [W-1:0] req_y = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_o;
    logic         rsp_zr, rsp_ng;
    logic [W-1:0] alu_x, alu_y, alu_o;
    logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic         alu_zr, alu_ng;
    logic [5:0]   ctrl_word;

    always #5 clk = ~clk;

    alu_sequencer #(.W(W), .MUL_STEPS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_x    (req_x),
        .req_y    (req_y),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_o    (rsp_o),
        .rsp_zr   (rsp_zr),
        .rsp_ng   (rsp_ng),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_zx   (alu_zx),
        .alu_nx   (alu_nx),
        .alu_zy   (alu_zy),
        .alu_ny   (alu_ny),
        .alu_f    (alu_f),
        .alu_no   (alu_no),
        .alu_o    (alu_o),
        .alu_zr   (alu_zr),
        .alu_ng   (alu_ng)
    );

    assign ctrl_word = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

    // Reference ALU the sequencer drives.
    logic [W-1:0] mx0, mx1, my0, my1, mf;
    always_comb begin
        mx0    = alu_zx ? '0 : alu_x;
        mx1    = alu_nx ? ~mx0 : mx0;
        my0    = alu_zy ? '0 : alu_y;
        my1    = alu_ny ? ~my0 : my0;
        mf     = alu_f ? (mx1 + my1) : (mx1 & my1);
        alu_o  = alu_no ? ~mf : mf;
        alu_zr = (alu_o == '0);
        alu_ng = alu_o[W-1];
    end

    typedef struct {
        logic [W-1:0] o;
        logic         zr;
        logic         ng;
        int           lat;
        int           hold;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    int   acc_edges[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   last_rsp_edge = -100;

    function automatic void chk(input string name, input int id, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, id, act, req);
        end
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Handshake seen at a negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) acc_edges.push_back(edge_cnt + 1);
    end

    // Monitor / consumer.
    exp_t cur;
    bit   in_rsp = 1'b0;
    int   hold = 0;
    int   lat;

    always @(negedge clk) begin
        if (rst) begin
            in_rsp    = 1'b0;
            rsp_ready = 1'b0;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                in_rsp = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", -1, 1, 0);
                    cur  = '{o: rsp_o, zr: rsp_zr, ng: rsp_ng, lat: 0, hold: 0, id: -1};
                    hold = 0;
                end else begin
                    cur  = exp_q.pop_front();
                    hold = cur.hold;
                    lat  = (acc_edges.size() > 0) ? (edge_cnt - acc_edges.pop_front() + 1) : -1;
                    chk("latency", cur.id, lat, cur.lat);
                    chk("rsp_o", cur.id, int'(rsp_o), int'(cur.o));
                    chk("rsp_zr", cur.id, int'(rsp_zr), int'(cur.zr));
                    chk("rsp_ng", cur.id, int'(rsp_ng), int'(cur.ng));
                end
            end else begin
                chk("hold_o", cur.id, int'(rsp_o), int'(cur.o));
                chk("hold_flags", cur.id, int'({rsp_zr, rsp_ng}), int'({cur.zr, cur.ng}));
            end
            chk("req_ready_busy", cur.id, int'(req_ready), 0);
            if (hold > 0) begin
                rsp_ready = 1'b0;
                hold--;
            end else begin
                rsp_ready     = 1'b1;
                last_rsp_edge = edge_cnt + 1;
            end
        end else begin
            in_rsp    = 1'b0;
            rsp_ready = 1'b0;
        end
    end

    task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp_o,
                         input logic [5:0] exp_ctrl, input int hold_cyc, output int acc_edge);
        exp_t e;
        e.o    = exp_o;
        e.zr   = (exp_o == '0);
        e.ng   = exp_o[W-1];
        e.lat  = (op == 4'd15) ? 9 : 2;
        e.hold = hold_cyc;
        e.id   = id;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        acc_edge  = -1;
        for (int i = 0; i < 100 && acc_edge < 0; i++) begin
            @(negedge clk);
            if (req_ready) acc_edge = edge_cnt + 1;
        end
        if (acc_edge < 0) begin
            chk("accept_timeout", id, 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        // First cycle after accept: EXEC or MULT step 0.
        @(negedge clk);
        chk("alu_ctrl", id, int'(ctrl_word), int'(exp_ctrl));
        if (op == 4'd15) begin
            chk("alu_x", id, int'(alu_x), 0);
            chk("alu_y", id, int'(alu_y), int'(x));
        end else begin
            chk("alu_x", id, int'(alu_x), int'(x));
            chk("alu_y", id, int'(alu_y), int'(y));
        end
    endtask

    // Sweep with x=0x3C, y=0x0F: control words and hand-computed results.
    logic [5:0]   sw_c[15] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                               6'b001101, 6'b110001, 6'b001111, 6'b010101, 6'b011111,
                               6'b110111, 6'b001110, 6'b000010, 6'b010011, 6'b000000};
    logic [W-1:0] sw_o[15] = '{8'h00, 8'h01, 8'hFF, 8'h3C, 8'h0F, 8'hC3, 8'hF0, 8'hC4,
                               8'h3F, 8'h3D, 8'h10, 8'h3B, 8'h4B, 8'h2D, 8'h0C};

    initial begin
        int ae;
        int ae2;

        // Held in reset: state is already IDLE but req_ready must stay low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 0, int'(req_ready), 0);
        chk("rst_rsp_valid", 0, int'(rsp_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 0, int'(req_ready), 1);
        chk("post_rst_rsp_o", 0, int'(rsp_o), 0);
        chk("post_rst_flags", 0, int'({rsp_zr, rsp_ng}), 0);
        chk("idle_ctrl", 0, int'(ctrl_word), int'(CtrlZero));
        chk("idle_xy", 0, int'({alu_x, alu_y}), 0);

        issue(1, 4'd12, 8'h7F, 8'h01, 8'h80, CtrlXPlusY, 0, ae);   // XPLUSY -> 0x80, ng
        issue(2, 4'd13, 8'h05, 8'h05, 8'h00, 6'b010011, 0, ae);    // XMINUSY -> 0, zr
        issue(3, 4'd7, 8'h01, 8'h00, 8'hFF, 6'b001111, 0, ae);     // NEGX -> 0xFF
        issue(4, 4'd15, 8'd13, 8'd11, 8'h8F, CtrlXPlusY, 0, ae);   // 143 = 0x8F
        issue(5, 4'd15, 8'h10, 8'h10, 8'h00, CtrlXPlusY, 0, ae);   // 0x100 wraps to 0
        issue(6, 4'd15, 8'hFF, 8'hFF, 8'h01, CtrlXPlusY, 0, ae);   // 0xFE01 -> 0x01

        // Backpressure for 3 cycles, then the next request on the following edge.
        issue(7, 4'd9, 8'h41, 8'h00, 8'h42, 6'b011111, 3, ae);
        issue(8, 4'd14, 8'hF0, 8'h3C, 8'h30, 6'b000000, 0, ae2);
        chk("b2b_gap", 8, ae2 - last_rsp_edge, 1);

        // Reset during MULT step 4: request is dropped, block returns to IDLE.
        issue(9, 4'd15, 8'd3, 8'd5, 8'h0F, CtrlXPlusY, 0, ae);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        acc_edges.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midmul_rst_rsp_valid", 9, int'(rsp_valid), 0);
        chk("midmul_rst_req_ready", 9, int'(req_ready), 1);
        chk("midmul_rst_ctrl", 9, int'(ctrl_word), int'(CtrlZero));
        issue(10, 4'd1, 8'h55, 8'hAA, 8'h01, CtrlOne, 0, ae);

        for (int i = 0; i < 15; i++) begin
            issue(100 + i, 4'(i), 8'h3C, 8'h0F, sw_o[i], sw_c[i], 0, ae);
        end

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain", 0, exp_q.size(), 0);
        // Window for any stray response to surface.
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command front-end that drives the team's 8-bit six-control-bit ALU (zx, nx, zy, ny, f, no → o, zr, ng) from the controlling side.
- Accepts opcode/operand requests over a valid/ready handshake and encodes each opcode into the ALU control word.
- Single-cycle ops are captured after one cycle. MUL is executed as an 8-step shift-add loop through the same ALU. Results, including zr/ng, are returned over a second valid/ready handshake.

Parameters:
- W, 8, datapath width; must match ALU width.
- MUL_STEPS, 8, shift-add iterations for MUL; must equal W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  4  opcode (see Behaviour).
- req_x  input  W  operand x.
- req_y  input  W  operand y.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer accepts result.
- rsp_o  output  W  result.
- rsp_zr  output  1  result == 0.
- rsp_ng  output  1  result[W-1].
- alu_x, alu_y  output  W  operands to ALU.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control word.
- alu_o  input  W  ALU result (combinational, same cycle).
- alu_zr, alu_ng  input  1  ALU flags.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Opcode → control word, in the order zx nx zy ny f no:
  - 0 ZERO 101010
  - 1 ONE 111111
  - 2 NEG1 111010
  - 3 X 001100
  - 4 Y 110000
  - 5 NOTX 001101
  - 6 NOTY 110001
  - 7 NEGX 001111
  - 8 XORY 010101
  - 9 XPLUS1 011111
  - 10 YPLUS1 110111
  - 11 XMINUS1 001110
  - 12 XPLUSY 000010
  - 13 XMINUSY 010011
  - 14 XANDY 000000
  - 15 MUL: unsigned product, low W bits; uses XPLUSY internally.
- FSM states: IDLE, EXEC, MULT, RESP.
- IDLE:
  - req_ready=1.
  - ALU driven with x=0, y=0, ZERO control word.
  - On req_valid: latch op/x/y. Go to MULT if op==15, else EXEC.
- EXEC (exactly 1 cycle):
  - ALU driven with the latched x/y and decoded control word.
  - At the clock edge, capture alu_o/alu_zr/alu_ng into the response registers; go to RESP.
- MULT:
  - On entry: acc=0, mcand=x, mplier=y, cnt=0.
  - Each cycle: alu_x=acc, alu_y=mcand, control word XPLUSY.
  - If mplier[0]=1, acc←alu_o.
  - Every cycle: mcand←mcand<<1 (bits shifted out discarded); mplier←mplier>>1; cnt++.
  - After MUL_STEPS cycles, go to RESP with rsp_o=acc_final, rsp_zr=(acc_final==0), rsp_ng=acc_final[W-1].
  - No early termination; fixed latency.
- RESP:
  - rsp_valid=1; rsp_o/zr/ng held stable.
  - On rsp_ready, go to IDLE (rsp_valid low next cycle).
- req_ready is 1 only in IDLE; no new request overlaps an in-flight one.
- Latency from the accept edge to rsp_valid high:
  - single-cycle ops: 2 edges (EXEC, then RESP);
  - MUL: MUL_STEPS+1 edges.
- Back-to-back: rsp accepted at edge N → IDLE at N → next request may be accepted at edge N+1.
- Arithmetic is modulo 2^W; overflow is silently wrapped, with no flag.
- Reset values: req_ready=0 during reset and 1 after; rsp_valid=0; rsp_o=0; rsp_zr=0; rsp_ng=0; alu_* = IDLE drive; all internal registers=0; state=IDLE.
- rst asserted in any state, including mid-MULT or RESP: the next edge returns to IDLE and drops any pending result; no response is emitted for that request.
- req_valid while not in IDLE is ignored; the requester holds it under the handshake.

Test Plan:
- XPLUSY x=0x7F y=0x01 → rsp_o=0x80, zr=0, ng=1; rsp_valid 2 edges after accept.
- XMINUSY x=0x05 y=0x05 → rsp_o=0x00, zr=1, ng=0. NEGX x=0x01 → 0xFF, ng=1.
- MUL x=13 y=11 → rsp_o=0x8F, ng=1, zr=0, rsp_valid exactly 9 edges after accept. MUL x=0x10 y=0x10 → 0x00, zr=1 (wrap).
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid → rsp_o/zr/ng stable and req_ready=0 throughout; accept, then a new request is taken the next cycle.
- Reset mid-MUL: assert rst at cycle 4 of MULT → next cycle state IDLE, rsp_valid=0, req_ready=1; a following ONE request → rsp_o=0x01.
- Sweep all 15 single-cycle opcodes with x=0x3C, y=0x0F; compare alu_* control outputs and rsp_o against the encoding list.
